alu_pwr_seq_ctrl: RTL and testbench



---
 rtl/alu_pwr_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_pwr_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_pwr_seq_ctrl
// Purpose  : Power/isolation sequencer and start-pulse issuer for the gated ALU
// Revision : 1.0
// ============================================================================
module alu_pwr_seq_ctrl #(
   parameter int RAMP_CYC = 4,
   parameter int ISO_CYC  = 2,
   parameter int IDLE_CYC = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_req,
   input  logic       force_off,
   input  logic       alu_busy,
   output logic       op_ack,
   output logic       alu_start,
   output logic       alu_pwr_en,
   output logic       iso_en,
   output logic [1:0] pwr_state,
   output logic       ready
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RAMP = 2'd1,
      ST_ON   = 2'd2,
      ST_ISO  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_ramp_ld = CNT_W'(RAMP_CYC - 1);
   localparam logic [CNT_W-1:0] c_iso_ld  = CNT_W'(ISO_CYC - 1);
   localparam logic [CNT_W-1:0] c_idle_ld = CNT_W'(IDLE_CYC);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pwr_en_q, pwr_en_d;
   logic             iso_en_q, iso_en_d;
   logic             op_ack_q, op_ack_d;
   logic             alu_start_q, alu_start_d;
   logic             ready_q, ready_d;

   logic w_grant;
   logic w_idle;
   logic w_shutdown;

   // The previous-cycle start acts as a guard while the ALU raises busy.
   assign w_grant    = op_req && !force_off && !alu_busy && !alu_start_q;
   assign w_idle     = !op_req && !alu_busy && !alu_start_q;
   assign w_shutdown = force_off && !alu_busy && !alu_start_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_ack_d    = 1'b0;
      alu_start_d = 1'b0;

      case (state_q)
         ST_OFF: begin
            if (op_req && !force_off) begin
               state_d = ST_RAMP;
               cnt_d   = c_ramp_ld;
            end
         end
         ST_RAMP: begin
            if (cnt_q == '0) begin
               state_d = ST_ON;
               cnt_d   = c_idle_ld;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ON: begin
            if (w_shutdown || (w_idle && cnt_q <= c_one)) begin
               state_d = ST_ISO;
               cnt_d   = c_iso_ld;
            end else if (w_grant) begin
               op_ack_d    = 1'b1;
               alu_start_d = 1'b1;
               cnt_d       = c_idle_ld;
            end else if (w_idle) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = c_idle_ld;
            end
         end
         ST_ISO: begin
            if (cnt_q == '0) begin
               state_d = ST_OFF;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase

      // Outputs derive from the next state so the safety invariant holds by construction.
      pwr_en_d = (state_d != ST_OFF);
      iso_en_d = (state_d != ST_ON);
      ready_d  = (state_d == ST_ON);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         pwr_en_q    <= 1'b0;
         iso_en_q    <= 1'b1;
         op_ack_q    <= 1'b0;
         alu_start_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pwr_en_q    <= pwr_en_d;
         iso_en_q    <= iso_en_d;
         op_ack_q    <= op_ack_d;
         alu_start_q <= alu_start_d;
         ready_q     <= ready_d;
      end
   end

   assign op_ack     = op_ack_q;
   assign alu_start  = alu_start_q;
   assign alu_pwr_en = pwr_en_q;
   assign iso_en     = iso_en_q;
   assign pwr_state  = state_q;
   assign ready      = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pwr_seq_ctrl
// Purpose  : Directed self-checking bench for alu_pwr_seq_ctrl
// Revision : 1.0
// ============================================================================
module tb_alu_pwr_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       op_req = 1'b0;
   logic       force_off = 1'b0;
   logic       alu_busy = 1'b0;
   logic       op_ack;
   logic       alu_start;
   logic       alu_pwr_en;
   logic       iso_en;
   logic [1:0] pwr_state;
   logic       ready;

   int n_chk = 0;
   int n_err = 0;
   logic inv_en = 1'b0;

   localparam logic [1:0] c_off  = 2'd0;
   localparam logic [1:0] c_ramp = 2'd1;
   localparam logic [1:0] c_on   = 2'd2;
   localparam logic [1:0] c_iso  = 2'd3;

   alu_pwr_seq_ctrl #(
      .RAMP_CYC (4),
      .ISO_CYC  (2),
      .IDLE_CYC (16),
      .CNT_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .op_req     (op_req),
      .force_off  (force_off),
      .alu_busy   (alu_busy),
      .op_ack     (op_ack),
      .alu_start  (alu_start),
      .alu_pwr_en (alu_pwr_en),
      .iso_en     (iso_en),
      .pwr_state  (pwr_state),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] st, input logic pwr,
                             input logic iso, input logic ack);
      check_val({tag, "_state"}, 32'(pwr_state), 32'(st));
      check_val({tag, "_pwr"},   32'(alu_pwr_en), 32'(pwr));
      check_val({tag, "_iso"},   32'(iso_en), 32'(iso));
      check_val({tag, "_ack"},   32'(op_ack), 32'(ack));
   endtask

   // Safety and output-consistency invariants, sampled mid-cycle.
   always @(negedge clk) begin
      if (inv_en) begin
         check_val("inv_iso_only_on", 32'(!iso_en && pwr_state != c_on), 32'd0);
         check_val("inv_pwr_off_only_off", 32'(!alu_pwr_en && pwr_state != c_off), 32'd0);
         check_val("inv_ready", 32'(ready), 32'(pwr_state == c_on));
         check_val("inv_ack_eq_start", 32'(op_ack), 32'(alu_start));
         check_val("inv_ack_only_on", 32'(op_ack && pwr_state != c_on), 32'd0);
      end
   end

   initial begin
      // Reset and wake
      rst = 1'b1;
      tick();
      tick();
      expect_out("rst", c_off, 1'b0, 1'b1, 1'b0);
      check_val("rst_ready", 32'(ready), 32'd0);
      check_val("rst_start", 32'(alu_start), 32'd0);
      rst = 1'b0;
      inv_en = 1'b1;
      op_req = 1'b1;
      tick();
      expect_out("wake_e0", c_ramp, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("wake_ramp", c_ramp, 1'b1, 1'b1, 1'b0);
      end
      tick();
      expect_out("wake_on", c_on, 1'b1, 1'b0, 1'b0);
      check_val("wake_ready", 32'(ready), 32'd1);
      tick();
      expect_out("wake_grant", c_on, 1'b1, 1'b0, 1'b1);
      check_val("wake_start", 32'(alu_start), 32'd1);
      op_req = 1'b0;
      tick();
      expect_out("wake_noack2", c_on, 1'b1, 1'b0, 1'b0);

      // Idle timeout: 16 idle edges after the guard cycle
      for (int i = 0; i < 15; i++) begin
         tick();
         expect_out("idle_on", c_on, 1'b1, 1'b0, 1'b0);
      end
      tick();
      expect_out("idle_iso1", c_iso, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("idle_iso2", c_iso, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("idle_off", c_off, 1'b0, 1'b1, 1'b0);

      // Busy with force_off
      op_req = 1'b1;
      tick();
      expect_out("bz_ramp", c_ramp, 1'b1, 1'b1, 1'b0);
      op_req = 1'b0;
      repeat (4) tick();
      expect_out("bz_on", c_on, 1'b1, 1'b0, 1'b0);
      alu_busy = 1'b1;
      tick();
      expect_out("bz_busy", c_on, 1'b1, 1'b0, 1'b0);
      force_off = 1'b1;
      op_req = 1'b1;
      tick();
      expect_out("bz_force1", c_on, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("bz_force2", c_on, 1'b1, 1'b0, 1'b0);
      alu_busy = 1'b0;
      tick();
      expect_out("bz_iso", c_iso, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      expect_out("bz_off", c_off, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("bz_hold_off1", c_off, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("bz_hold_off2", c_off, 1'b0, 1'b1, 1'b0);
      force_off = 1'b0;
      tick();
      expect_out("bz_rewake", c_ramp, 1'b1, 1'b1, 1'b0);
      repeat (4) tick();
      expect_out("b2b_on", c_on, 1'b1, 1'b0, 1'b0);

      // Back-to-back requests: starts every other cycle
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_out("b2b", c_on, 1'b1, 1'b0, ((i % 2) == 0) ? 1'b1 : 1'b0);
         check_val("b2b_start", 32'(alu_start), ((i % 2) == 0) ? 32'd1 : 32'd0);
      end

      // Request raised during ISO
      op_req = 1'b0;
      force_off = 1'b1;
      tick();
      expect_out("riso_iso1", c_iso, 1'b1, 1'b1, 1'b0);
      op_req = 1'b1;
      force_off = 1'b0;
      tick();
      expect_out("riso_iso2", c_iso, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("riso_off", c_off, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_out("riso_ramp", c_ramp, 1'b1, 1'b1, 1'b0);
      end
      tick();
      expect_out("riso_on", c_on, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("riso_grant", c_on, 1'b1, 1'b0, 1'b1);

      // Reset mid-ISO
      op_req = 1'b0;
      tick();
      force_off = 1'b1;
      tick();
      expect_out("rmid_iso", c_iso, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("rmid_iso_rst", c_off, 1'b0, 1'b1, 1'b0);
      check_val("rmid_iso_start", 32'(alu_start), 32'd0);

      // Reset mid-RAMP with counter at 2
      rst = 1'b0;
      force_off = 1'b0;
      op_req = 1'b1;
      tick();
      tick();
      expect_out("rmid_ramp", c_ramp, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("rmid_ramp_rst", c_off, 1'b0, 1'b1, 1'b0);
      check_val("rmid_ramp_start", 32'(alu_start), 32'd0);
      rst = 1'b0;
      tick();
      expect_out("post_rst_wake", c_ramp, 1'b1, 1'b1, 1'b0);

      inv_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
